// File: rtl/morse_key_classifier.sv
// Single-key Morse front end: turns press/release durations into dot, dash, enter and backspace pulses.
// Optional MORSE_KEY_SYNC_EN adds a 2-flop synchronizer in front of the key sample register.
module morse_key_classifier #(
  parameter int UNIT_CYC   = 10_000_000,
  parameter int DASH_UNITS = 2,
  parameter int GAP_UNITS  = 3,
  parameter int LONG_UNITS = 10,
  parameter int MAX_SYM    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       dot_pulse,
  output logic       dash_pulse,
  output logic       enter_pulse,
  output logic       back_pulse,
  output logic       key_active,
  output logic [2:0] sym_count
);

  localparam int PW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYC - 1);
  localparam logic [4:0]    DASH_U     = 5'(DASH_UNITS);
  localparam logic [4:0]    GAP_LAST   = 5'(GAP_UNITS - 1);
  localparam logic [4:0]    LONG_LAST  = 5'(LONG_UNITS - 1);
  localparam logic [2:0]    SYM_MAX    = 3'(MAX_SYM);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_HOLD} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [4:0]    r_units;
  logic          r_key_s;
  logic          w_key_raw;
  logic          w_tick;
  logic          w_long_hit;
  logic          w_gap_hit;

`ifdef MORSE_KEY_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], key_in};
  end

  assign w_key_raw = r_sync[1];
`else
  assign w_key_raw = key_in;
`endif

  // Deliberately not reset: a key still held through reset must stay visible so S_HOLD can swallow it.
  always_ff @(posedge clk) begin
    r_key_s <= w_key_raw;
  end

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_long_hit = w_tick && (r_units == LONG_LAST);
  assign w_gap_hit  = w_tick && (r_units == GAP_LAST);

  // Timebase defaults first; state transitions into S_PRESS/S_GAP override them to restart timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_HOLD;
      r_presc     <= '0;
      r_units     <= '0;
      dot_pulse   <= 1'b0;
      dash_pulse  <= 1'b0;
      enter_pulse <= 1'b0;
      back_pulse  <= 1'b0;
      key_active  <= 1'b0;
      sym_count   <= '0;
    end else begin
      dot_pulse   <= 1'b0;
      dash_pulse  <= 1'b0;
      enter_pulse <= 1'b0;
      back_pulse  <= 1'b0;

      if (w_tick) begin
        r_presc <= '0;
        if (r_units != 5'd31) r_units <= r_units + 5'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (r_key_s) begin
            r_state    <= S_PRESS;
            key_active <= 1'b1;
            r_presc    <= '0;
            r_units    <= '0;
          end
        end
        S_PRESS: begin
          if (w_long_hit) begin
            back_pulse <= 1'b1;
            sym_count  <= '0;
            key_active <= 1'b0;
            r_state    <= S_HOLD;
          end else if (!r_key_s) begin
            if (sym_count < SYM_MAX) begin
              if (r_units < DASH_U) dot_pulse  <= 1'b1;
              else                  dash_pulse <= 1'b1;
              sym_count <= sym_count + 3'd1;
            end
            key_active <= 1'b0;
            r_state    <= S_GAP;
            r_presc    <= '0;
            r_units    <= '0;
          end
        end
        S_GAP: begin
          if (r_key_s) begin
            r_state    <= S_PRESS;
            key_active <= 1'b1;
            r_presc    <= '0;
            r_units    <= '0;
          end else if (w_gap_hit) begin
            enter_pulse <= 1'b1;
            sym_count   <= '0;
            r_state     <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!r_key_s) r_state <= S_IDLE;
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier: expected pulses (kind + edge) go into a scoreboard queue.
`timescale 1ns/1ps
module tb_morse_key_classifier;

  localparam int UNIT  = 4;
  localparam int GAPU  = 3;
  localparam int LONGU = 10;

  localparam int K_NONE  = -1;
  localparam int K_DOT   = 0;
  localparam int K_DASH  = 1;
  localparam int K_ENTER = 2;
  localparam int K_BACK  = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in = 1'b0;
  logic       dot_pulse, dash_pulse, enter_pulse, back_pulse, key_active;
  logic [2:0] sym_count;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   lastRel = 0;
  exp_t sbQ[$];

  morse_key_classifier #(
    .UNIT_CYC(UNIT), .DASH_UNITS(2), .GAP_UNITS(GAPU), .LONG_UNITS(LONGU), .MAX_SYM(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .dot_pulse(dot_pulse), .dash_pulse(dash_pulse), .enter_pulse(enter_pulse),
    .back_pulse(back_pulse), .key_active(key_active), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press for p cycles; the classified pulse lands one edge after key_s first sees the release.
  task automatic applyStimulus(input int p, input int kind, input int symAfter);
    int e;
    exp_t x;
    key_in = 1'b1;
    e = cyc;
    if (p >= LONGU * UNIT) begin
      x.kind = K_BACK;
      x.cyc  = e + 2 + LONGU * UNIT;
      sbQ.push_back(x);
    end
    waitCycles(3);
    checkOutput("key_active_press", int'(key_active), 1);
    waitCycles(p - 3);
    key_in  = 1'b0;
    lastRel = e + p + 2;
    if (kind != K_NONE) begin
      x.kind = kind;
      x.cyc  = lastRel;
      sbQ.push_back(x);
    end
    waitCycles(2);
    checkOutput("key_active_release", int'(key_active), 0);
    checkOutput("sym_after_release", int'(sym_count), symAfter);
  endtask

  task automatic gapStep(input int g, input bit expectEnter, input int symAfter);
    exp_t x;
    if (expectEnter) begin
      x.kind = K_ENTER;
      x.cyc  = lastRel + GAPU * UNIT;
      sbQ.push_back(x);
    end
    waitCycles(g - 2);
    checkOutput("sym_after_gap", int'(sym_count), symAfter);
  endtask

  always @(negedge clk) begin
    int n;
    int k;
    exp_t e;
    n = int'(dot_pulse) + int'(dash_pulse) + int'(enter_pulse) + int'(back_pulse);
    if (n != 0) begin
      checkOutput("pulse_onehot", n, 1);
      k = {30'd0, enter_pulse | back_pulse, dash_pulse | back_pulse};
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_pulse", k, K_NONE);
      end else begin
        e = sbQ.pop_front();
        checkOutput("pulse_kind", k, e.kind);
        checkOutput("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e;
    // Reset with key low
    rst_n  = 1'b0;
    key_in = 1'b0;
    waitCycles(3);
    checkOutput("reset_sym", int'(sym_count), 0);
    checkOutput("reset_active", int'(key_active), 0);
    checkOutput("reset_pulses", int'({dot_pulse, dash_pulse, enter_pulse, back_pulse}), 0);
    rst_n = 1'b1;

    $display("[TB] test 1: dot then enter");
    applyStimulus(5, K_DOT, 1);
    gapStep(20, 1'b1, 0);

    $display("[TB] test 2: dash");
    applyStimulus(12, K_DASH, 1);
    gapStep(20, 1'b1, 0);

    $display("[TB] test 3: long press backspace");
    applyStimulus(45, K_NONE, 0);
    gapStep(20, 1'b0, 0);

    $display("[TB] test 4: six dots saturate at five");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(3, K_DOT, i);
      gapStep(4, 1'b0, i);
    end
    applyStimulus(3, K_NONE, 5);
    gapStep(20, 1'b1, 0);

    $display("[TB] test 5: short gap between symbols");
    applyStimulus(5, K_DOT, 1);
    gapStep(8, 1'b0, 1);
    applyStimulus(5, K_DOT, 2);
    gapStep(20, 1'b1, 0);

    $display("[TB] test 6: reset mid-press");
    applyStimulus(5, K_DOT, 1);
    gapStep(8, 1'b0, 1);
    key_in = 1'b1;
    e = cyc;
    waitCycles(6);
    checkOutput("unit1_reached", cyc - e, 6);
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    checkOutput("midreset_sym", int'(sym_count), 0);
    checkOutput("midreset_active", int'(key_active), 0);
    waitCycles(10);
    checkOutput("held_after_reset_active", int'(key_active), 0);
    key_in = 1'b0;
    waitCycles(20);
    applyStimulus(5, K_DOT, 1);
    gapStep(20, 1'b1, 0);

    waitCycles(30);
    checkOutput("sb_drained", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
